alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle successor to the single-cycle 16-bit datapath ALU. It keeps the existing 4-bit opcode map (0000–1000) and adds subtract, signed compare/branch, and iterative signed multiply and unsigned divide/remainder. Operands enter and results leave through valid/ready handshakes, so the execute stage can stall on long operations. It sits in the execute stage between the register-read pipeline register and the writeback/branch-resolve logic.

## Interface
- WIDTH, 16, operand/result width; must be ≥ 4.
- SHW, $clog2(WIDTH), derived; not overridable.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A (signed unless noted).
- b  in  WIDTH  operand B (signed unless noted).
- s  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result this cycle.
- f  out  WIDTH  result.
- ovf  out  1  overflow / divide-by-zero flag.
- take_branch  out  1  branch decision.
- busy  out  1  high in EXEC state.

## Operation
- Opcodes:
  - 0000 ADD: f=a+b; ovf on signed overflow.
  - 0001 NOT: f=~b.
  - 0010 AND.
  - 0011 OR.
  - 0100 SRA: f=a>>>b.
  - 0101 SLL: f=a<<b.
  - 0110 BEQZ: take_branch=(a==0), f=0.
  - 0111 BNEZ: take_branch=(a!=0), f=0.
  - 1000 XOR.
  - 1001 SUB: f=a-b; ovf on signed overflow.
  - 1010 SLT: f=(a<b signed)?1:0.
  - 1011 BLT: take_branch=(a<b signed), f=0.
  - 1100 MUL: signed; f = low WIDTH bits of the 2·WIDTH product; ovf=1 iff the product is not representable in WIDTH signed bits.
  - 1101 DIVU: unsigned quotient.
  - 1110 REMU: unsigned remainder.
  - 1111: reserved; f=0, ovf=0, take_branch=0.
- Unless listed, ovf=0 and take_branch=0.
- Shift count is b treated as unsigned over its full width. If b≥WIDTH: SLL gives 0; SRA gives all copies of a[WIDTH-1].
- Divide by zero (b==0): DIVU gives f = all ones; REMU gives f=a; ovf=1 for both. Handled in the same cycle count as a normal divide.
- MUL: shift-add on operand magnitudes, one multiplier bit per cycle, sign applied at completion.
- DIVU/REMU: restoring division, one quotient bit per cycle.
- FSM:
  - IDLE: in_ready=1. On accept, opcodes 1100–1110 go to EXEC and all others go to DONE.
  - EXEC: iteration counter runs WIDTH cycles, then goes to DONE.
  - DONE: out_valid=1. If out_ready is high and there is no new accept, go to IDLE. If out_ready and in_valid are both high, accept the new operation in the same cycle (in_ready = out_ready in DONE) and branch as from IDLE.
- f, ovf and take_branch are registered and stay stable while out_valid && !out_ready.
- Operands are captured on accept. Changes on a, b or s after the accept edge have no effect.

## Timing
- Reset values: in_ready=0 while rst is asserted, then 1 from the first clock after deassertion. out_valid=0, busy=0, f=0, ovf=0, take_branch=0. FSM goes to IDLE and the counter clears.
- Accept happens at an edge where in_valid && in_ready.
- Single-cycle ops: out_valid is high in the cycle after the accept edge (latency 1). With out_ready held high, throughput is 1 op/cycle.
- MUL/DIVU/REMU: busy is high for WIDTH cycles, and out_valid rises WIDTH+1 cycles after the accept edge (17 for WIDTH=16). in_ready=0 throughout EXEC.
- A result is consumed at an edge where out_valid && out_ready. out_valid drops the next cycle unless a back-to-back single-cycle op was accepted at that edge.
- rst asserted mid-EXEC or while DONE is stalled: the operation is aborted immediately and the result is discarded; all outputs take their reset values asynchronously.
- in_valid during EXEC is ignored. Upstream must hold in_valid and its operands until accepted.

## Test plan
- ADD, WIDTH=16: a=0x7FFF, b=0x0001, out_ready=1 → one cycle later f=0x8000, ovf=1, out_valid pulse 1 cycle.
- Back-to-back: XOR 0x00FF^0x0F0F then SLT a=0xFFFF, b=0x0001 on consecutive cycles → f=0x0FF0, then f=0x0001, on consecutive cycles; in_ready never drops.
- MUL: a=0xFFFD (−3), b=0x0007 → out_valid 17 cycles after accept, f=0xFFEB, ovf=0. Then a=0x0100, b=0x0100 → f=0x0000, ovf=1.
- DIVU/REMU: a=100, b=7 → f=14 and f=2 respectively. With b=0, a=0x1234: DIVU → f=0xFFFF, ovf=1; REMU → f=0x1234, ovf=1.
- Backpressure and shifts: SRA a=0x8000, b=20 with out_ready=0 for 5 cycles → f=0xFFFF held stable and in_ready=0 until out_ready=1. BLT a=0xFFFE, b=0x0001 → take_branch=1.
- Reset mid-divide: assert rst 5 cycles into DIVU → out_valid=0, busy=0 and f=0 immediately. After release, a new ADD completes normally with latency 1. Repeat the scenario at WIDTH=32 for MUL latency 33.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle execute-stage ALU. Single-cycle ops (add, sub,
//            logic, shifts, compare, branch) finish one cycle after accept.
//            MUL (signed shift-add on magnitudes) and DIVU/REMU (restoring
//            division) iterate one bit per cycle. A finish step follows,
//            which applies the product sign and the overflow flags.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready   - operand handshake (a, b, s)
//            out_valid/out_ready - result handshake (f, ovf, take_branch)
//            busy                - high while iterating
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter  int WIDTH = 16,              // must be >= 4
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf,
  output logic             take_branch,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   c_last  = SHW'(WIDTH - 1);

  state_t           r_state;
  logic             r_rdy_en;   // holds in_ready low until the first clock after reset
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_op;       // s[1:0] of the long op: 00 MUL, 01 DIVU, 10 REMU
  logic             r_neg;      // product sign
  logic             r_bzero;    // divisor was zero
  logic [2*WIDTH-1:0] r_acc;    // MUL: product accumulator; DIV: remainder in [WIDTH:0]
  logic [2*WIDTH-1:0] r_opa;    // MUL: shifted multiplicand; DIV: divisor in low bits
  logic [WIDTH-1:0]   r_opb;    // MUL: multiplier shifting out; DIV: dividend out / quotient in

  logic             w_accept;
  logic             w_long;
  logic [WIDTH-1:0] w_sum, w_diff, w_sra, w_mag_a, w_mag_b;
  logic [SHW-1:0]   w_sh;
  logic             w_big, w_lt;
  logic [WIDTH-1:0] w_f;
  logic             w_ovf, w_tb;
  logic [WIDTH:0]   w_rem_sh, w_rem_nx;
  logic             w_dge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]   w_hi;
  logic             w_movf;

  assign in_ready  = r_rdy_en && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_EXEC);
  assign w_accept  = in_valid && in_ready;
  assign w_long    = (s[3:2] == 2'b11) && (s[1:0] != 2'b11);

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_lt    = $signed(a) < $signed(b);
  assign w_big   = (b >= c_width);
  assign w_sh    = b[SHW-1:0];
  // Kept as its own assignment so the shift stays arithmetic.
  assign w_sra   = $signed(a) >>> w_sh;
  assign w_mag_a = a[WIDTH-1] ? -a : a;
  assign w_mag_b = b[WIDTH-1] ? -b : b;

  always_comb begin
    w_f   = '0;
    w_ovf = 1'b0;
    w_tb  = 1'b0;
    case (s)
      4'b0000: begin
        w_f   = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: w_f = ~b;
      4'b0010: w_f = a & b;
      4'b0011: w_f = a | b;
      4'b0100: w_f = w_big ? {WIDTH{a[WIDTH-1]}} : w_sra;
      4'b0101: w_f = w_big ? '0 : (a << w_sh);
      4'b0110: w_tb = (a == '0);
      4'b0111: w_tb = (a != '0);
      4'b1000: w_f = a ^ b;
      4'b1001: begin
        w_f   = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1010: w_f = {{(WIDTH-1){1'b0}}, w_lt};
      4'b1011: w_tb = w_lt;
      default: ;
    endcase
  end

  // Restoring-division step. A zero divisor always "fits", which yields an
  // all-ones quotient and leaves the dividend as remainder with no special case.
  assign w_rem_sh = {r_acc[WIDTH-1:0], r_opb[WIDTH-1]};
  assign w_dge    = (w_rem_sh >= {1'b0, r_opa[WIDTH-1:0]});
  assign w_rem_nx = w_dge ? (w_rem_sh - {1'b0, r_opa[WIDTH-1:0]}) : w_rem_sh;

  // Signed product fits in WIDTH bits iff bits [2W-1:W-1] are all equal.
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_hi   = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_movf = !((&w_hi) || !(|w_hi));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rdy_en    <= 1'b0;
      r_cnt       <= '0;
      r_op        <= 2'b00;
      r_neg       <= 1'b0;
      r_bzero     <= 1'b0;
      r_acc       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      f           <= '0;
      ovf         <= 1'b0;
      take_branch <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_long) begin
              r_op    <= s[1:0];
              r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
              r_bzero <= (b == '0);
              r_cnt   <= '0;
              r_acc   <= '0;
              if (s[1:0] == 2'b00) begin
                r_opa <= {{WIDTH{1'b0}}, w_mag_a};
                r_opb <= w_mag_b;
              end else begin
                r_opa <= {{WIDTH{1'b0}}, b};
                r_opb <= a;
              end
              r_state <= ST_EXEC;
            end else begin
              f           <= w_f;
              ovf         <= w_ovf;
              take_branch <= w_tb;
              r_state     <= ST_DONE;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (r_op == 2'b00) begin
            if (r_opb[0]) begin
              r_acc <= r_acc + r_opa;
            end
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end else begin
            r_acc <= {{(WIDTH-1){1'b0}}, w_rem_nx};
            r_opb <= {r_opb[WIDTH-2:0], w_dge};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          case (r_op)
            2'b00: begin
              f   <= w_prod[WIDTH-1:0];
              ovf <= w_movf;
            end
            2'b01: begin
              f   <= r_opb;
              ovf <= r_bzero;
            end
            default: begin
              f   <= r_acc[WIDTH-1:0];
              ovf <= r_bzero;
            end
          endcase
          take_branch <= 1'b0;
          r_state     <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
